yuv_block_writer: RTL and testbench
===================================

// Module: yuv_block_writer
// PURPOSE
// Upstream neighbour of the YUV->RGB colour-space/upsampling stage. Accepts the IDCT output
// stream as 8x8 sample blocks and writes it into SRAM as raster-ordered Y, U and V planes:
// Y 320x240, U/V 160x240, two samples per 16-bit word. The downstream stage reads these planes.
// Blocks arrive in order: all Y blocks, then all U blocks, then all V blocks; raster order within each plane.
// PARAMETERS
// Y_BLK_W    40     Y plane width in 8x8 blocks (320/8)
// UV_BLK_W   20     U/V plane width in 8x8 blocks (160/8)
// BLK_H      30     plane height in 8x8 blocks (240/8)
// Y_BASE     0      SRAM word address of Y plane
// U_BASE     38400  SRAM word address of U plane
// V_BASE     57600  SRAM word address of V plane
// PORTS
// Clock        in   1   system clock, all logic on rising edge
// Resetn       in   1   asynchronous active-low reset
// start_bit    in   1   one-cycle pulse; starts a full-frame write from IDLE
// in_valid     in   1   in_data holds one sample pair
// in_ready     out  1   block accepts in_data this cycle (in_valid & in_ready = accept)
// in_data      in   32  {even[15:0], odd[15:0]}, two horizontally adjacent signed IDCT samples
// address      out  18  SRAM word address
// write_data   out  16  {clip(even), clip(odd)}
// write_en_n   out  1   SRAM write enable, active low
// writer_finish out 1   one-cycle pulse after the final write of the frame
// BEHAVIOUR
// - Reset: state IDLE; address=0, write_data=0, write_en_n=1, in_ready=0, writer_finish=0, all counters 0.
// - FSM IDLE -> RUN on start_bit. RUN -> DONE after word 76800 is accepted. DONE -> IDLE after one cycle.
//   writer_finish=1 only in DONE. start_bit in RUN or DONE is ignored.
// - in_ready = 1 only in RUN; it is a function of state only and does not depend on in_valid.
// - Latency 1: a word accepted in cycle N drives write_en_n=0 plus address/data, all registered, in cycle N+1.
//   No accept in N -> write_en_n=1 in N+1; address/write_data hold their values.
// - Counters: col c 0..3 (word in block row), row r 0..7, block col bc, block row br 0..BLK_H-1, plane p (Y,U,V).
//   c advances per accept. r advances when c wraps. bc advances when r wraps. It wraps at Y_BLK_W or UV_BLK_W.
//   br advances when bc wraps. p advances when br wraps past BLK_H-1.
// - Address = base(p) + (br*8 + r)*pitch(p) + bc*4 + c; pitch Y=160, U/V=80 words.
//   Use shift-add only; no multiplier instance.
// - Clip per sample, signed 16-bit in: <0 -> 8'd0, >255 -> 8'd255, else low byte. Even sample in write_data[15:8].
// - Frame total: Y 38400 + U 19200 + V 19200 = 76800 words. The last write goes to address 76799.
// - Plane boundary: the first U word follows the last Y word (38399) with no idle cycle.
// - Reset mid-frame aborts the frame: counters clear and no further writes occur. A new start_bit restarts at Y_BASE.
// - in_valid while in_ready=0 is ignored; the upstream holds in_data.
// CONFIGURATION
// - BLOCK_WRITER_CLIP_STATS_EN defined: adds output clip_count [16:0], the number of samples saturated this frame.
//   It clears on start_bit, increments by 0/1/2 per accepted word, saturates at all-ones, and holds after DONE.
// - Not defined: the port and counter are absent. All other behaviour is identical.
// TESTING
// 1 Reset asserted mid-cycle -> immediately write_en_n=1, address=0, in_ready=0, writer_finish=0.
// 2 start_bit, then 32 words with in_data={16'd100,-16'sd5} -> writes 0x6400 at 0,1,2,3,160..163, ..., 1120..1123.
// 3 Clip: {16'd300,-16'sd1} -> 0xFF00. {16'd255,16'd0} -> 0xFF00. {-16'sd300,16'd256} -> 0x00FF.
//   With BLOCK_WRITER_CLIP_STATS_EN, clip_count goes 2, 2, 4 after each.
// 4 Block walk: word 33 -> address 4. Block 41 (br=1, bc=0) first word -> 1280. Word 38400 -> 38399.
// 5 Plane switch: word 38401 -> 38400 (U); U block 2 -> 38404; U row 1 -> 38480; word 57601 -> 57600 (V).
//   Word 76800 -> 76799, then writer_finish=1 for exactly one cycle, then IDLE.
// 6 in_valid toggled 1,0,0,1 -> write_en_n pattern 0,1,1,0 one cycle later with no address skip.
//   Resetn pulsed after word 500, then start_bit -> the next write goes to address 0.

Source files
------------

// File: rtl/yuv_block_writer_if.sv
// Sample-pair input stream plus SRAM write bus of the YUV block writer.
// slave = the block writer itself; master = whatever drives/observes it.
interface yuv_block_writer_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic [17:0] address;
   logic [15:0] write_data;
   logic        write_en_n;

   modport slave (
      input  in_valid, in_data,
      output in_ready, address, write_data, write_en_n
   );

   modport master (
      output in_valid, in_data,
      input  in_ready, address, write_data, write_en_n
   );
endinterface

// File: rtl/yuv_block_writer.sv
// Writes 8x8 IDCT sample blocks (Y, then U, then V) into raster-ordered SRAM planes.
// Optional BLOCK_WRITER_CLIP_STATS_EN adds clip_count, the saturated-sample count of the frame.
module yuv_block_writer #(
   parameter int unsigned Y_BLK_W  = 40,
   parameter int unsigned UV_BLK_W = 20,
   parameter int unsigned BLK_H    = 30,
   parameter int unsigned Y_BASE   = 0,
   parameter int unsigned U_BASE   = 38400,
   parameter int unsigned V_BASE   = 57600
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                start_bit,
   yuv_block_writer_if.slave   bus,
   output logic                writer_finish
`ifdef BLOCK_WRITER_CLIP_STATS_EN
   ,
   output logic [16:0]         clip_count
`endif
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   typedef enum logic [1:0] {PL_Y, PL_U, PL_V} plane_t;

   localparam int unsigned Y_PITCH  = Y_BLK_W * 4;
   localparam int unsigned UV_PITCH = UV_BLK_W * 4;
   localparam logic [5:0]  Y_BCOL_LAST  = 6'(Y_BLK_W - 1);
   localparam logic [5:0]  UV_BCOL_LAST = 6'(UV_BLK_W - 1);
   localparam logic [4:0]  BROW_LAST    = 5'(BLK_H - 1);

   state_t      state_reg;
   plane_t      plane_reg;
   logic [1:0]  col_reg;
   logic [2:0]  row_reg;
   logic [5:0]  bcol_reg;
   logic [4:0]  brow_reg;
   logic        in_ready_reg;
   logic        writer_finish_reg;
   logic        write_en_n_reg;
   logic [17:0] address_reg;
   logic [15:0] write_data_reg;

   logic        accept;
   logic        bcol_last;
   logic        row_wrap;
   logic        bcol_wrap;
   logic        brow_wrap;
   logic        plane_wrap;
   logic        frame_last;
   logic [7:0]  line;
   logic [17:0] base_sel;
   logic [17:0] line_off;
   logic [17:0] address_next;
   logic [7:0]  even_clip;
   logic [7:0]  odd_clip;
   logic [1:0]  clip_hits;

   // Constant multiply expressed as a sum of shifted copies, one per set pitch bit.
   function automatic logic [17:0] mul_pitch(input logic [7:0] v, input int unsigned k);
      logic [17:0] acc;
      acc = '0;
      for (int i = 0; i < 12; i++) begin
         if (k[i]) acc = acc + (18'(v) << i);
      end
      return acc;
   endfunction

   function automatic logic [7:0] clip8(input logic signed [15:0] s);
      if (s < 16'sd0)        return 8'd0;
      else if (s > 16'sd255) return 8'd255;
      else                   return s[7:0];
   endfunction

   function automatic logic is_clipped(input logic signed [15:0] s);
      return (s < 16'sd0) || (s > 16'sd255);
   endfunction

   assign accept     = in_ready_reg & bus.in_valid;
   assign bcol_last  = (bcol_reg == ((plane_reg == PL_Y) ? Y_BCOL_LAST : UV_BCOL_LAST));
   assign row_wrap   = (col_reg == 2'd3);
   assign bcol_wrap  = row_wrap & (row_reg == 3'd7);
   assign brow_wrap  = bcol_wrap & bcol_last;
   assign plane_wrap = brow_wrap & (brow_reg == BROW_LAST);
   assign frame_last = plane_wrap & (plane_reg == PL_V);

   assign line = {brow_reg, row_reg};

   always_comb begin
      base_sel = 18'(Y_BASE);
      line_off = mul_pitch(line, Y_PITCH);
      case (plane_reg)
         PL_U: begin
            base_sel = 18'(U_BASE);
            line_off = mul_pitch(line, UV_PITCH);
         end
         PL_V: begin
            base_sel = 18'(V_BASE);
            line_off = mul_pitch(line, UV_PITCH);
         end
         default: ;
      endcase
   end

   assign address_next = base_sel + line_off + {10'd0, bcol_reg, 2'b00} + {16'd0, col_reg};

   assign even_clip = clip8(bus.in_data[31:16]);
   assign odd_clip  = clip8(bus.in_data[15:0]);
   assign clip_hits = {1'b0, is_clipped(bus.in_data[31:16])} + {1'b0, is_clipped(bus.in_data[15:0])};

   // Control FSM; in_ready and writer_finish are registered alongside the state.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_reg         <= IDLE;
         in_ready_reg      <= 1'b0;
         writer_finish_reg <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               writer_finish_reg <= 1'b0;
               if (start_bit) begin
                  state_reg    <= RUN;
                  in_ready_reg <= 1'b1;
               end
            end
            RUN: begin
               if (accept && frame_last) begin
                  state_reg         <= DONE;
                  in_ready_reg      <= 1'b0;
                  writer_finish_reg <= 1'b1;
               end
            end
            DONE: begin
               state_reg         <= IDLE;
               writer_finish_reg <= 1'b0;
            end
            default: begin
               state_reg         <= IDLE;
               in_ready_reg      <= 1'b0;
               writer_finish_reg <= 1'b0;
            end
         endcase
      end
   end

   // Position counters: column word, row, block column, block row, plane.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         col_reg   <= '0;
         row_reg   <= '0;
         bcol_reg  <= '0;
         brow_reg  <= '0;
         plane_reg <= PL_Y;
      end else if (state_reg == IDLE && start_bit) begin
         col_reg   <= '0;
         row_reg   <= '0;
         bcol_reg  <= '0;
         brow_reg  <= '0;
         plane_reg <= PL_Y;
      end else if (accept) begin
         col_reg <= col_reg + 2'd1;
         if (row_wrap)  row_reg  <= row_reg + 3'd1;
         if (bcol_wrap) bcol_reg <= bcol_last ? 6'd0 : bcol_reg + 6'd1;
         if (brow_wrap) brow_reg <= (brow_reg == BROW_LAST) ? 5'd0 : brow_reg + 5'd1;
         if (plane_wrap) begin
            case (plane_reg)
               PL_Y:    plane_reg <= PL_U;
               PL_U:    plane_reg <= PL_V;
               default: plane_reg <= PL_Y;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         address_reg    <= '0;
         write_data_reg <= '0;
         write_en_n_reg <= 1'b1;
      end else begin
         write_en_n_reg <= ~accept;
         if (accept) begin
            address_reg    <= address_next;
            write_data_reg <= {even_clip, odd_clip};
         end
      end
   end

`ifdef BLOCK_WRITER_CLIP_STATS_EN
   logic [16:0] clip_count_reg;
   logic [17:0] clip_sum;

   assign clip_sum = {1'b0, clip_count_reg} + {16'd0, clip_hits};

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         clip_count_reg <= '0;
      end else if (state_reg == IDLE && start_bit) begin
         clip_count_reg <= '0;
      end else if (accept) begin
         clip_count_reg <= clip_sum[17] ? 17'h1FFFF : clip_sum[16:0];
      end
   end

   assign clip_count = clip_count_reg;
`else
   logic unused_clip;
   assign unused_clip = ^clip_hits;
`endif

   assign bus.in_ready   = in_ready_reg;
   assign bus.address    = address_reg;
   assign bus.write_data = write_data_reg;
   assign bus.write_en_n = write_en_n_reg;
   assign writer_finish  = writer_finish_reg;

endmodule

// File: tb/tb_yuv_block_writer.sv
// Scoreboard bench for yuv_block_writer: a frame-level model predicts every cycle's
// SRAM bus, in_ready, writer_finish (and clip_count when BLOCK_WRITER_CLIP_STATS_EN).
module tb_yuv_block_writer;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   logic start_bit = 1'b0;
   logic writer_finish;
`ifdef BLOCK_WRITER_CLIP_STATS_EN
   logic [16:0] clip_count;
`endif

   yuv_block_writer_if bus();

   yuv_block_writer dut (
      .clk           (clk),
      .resetn        (resetn),
      .start_bit     (start_bit),
      .bus           (bus),
      .writer_finish (writer_finish)
`ifdef BLOCK_WRITER_CLIP_STATS_EN
      ,
      .clip_count    (clip_count)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          acc;
      bit          rdy;
      bit          fin;
      logic [17:0] addr;
      logic [15:0] data;
      int          k;
      int          cc;
      bit          log_it;
   } rec_t;

   rec_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Frame-level model: 0 idle, 1 running, 2 done
   int m_state = 0;
   int m_k = 0;
   int m_cc = 0;

   localparam int FRAME_WORDS = 76800;

   function automatic int ref_addr(input int k);
      int base, pitch, bw, kk, b, w;
      if (k < 38400) begin
         base = 0; pitch = 160; bw = 40; kk = k;
      end else if (k < 57600) begin
         base = 38400; pitch = 80; bw = 20; kk = k - 38400;
      end else begin
         base = 57600; pitch = 80; bw = 20; kk = k - 57600;
      end
      b = kk / 32;
      w = kk % 32;
      return base + ((b / bw) * 8 + w / 4) * pitch + (b % bw) * 4 + (w % 4);
   endfunction

   function automatic int clip_val(input logic [15:0] v);
      int s;
      s = int'($signed(v));
      if (s < 0) return 0;
      if (s > 255) return 255;
      return s;
   endfunction

   function automatic int clip_hit(input logic [15:0] v);
      int s;
      s = int'($signed(v));
      return (s < 0 || s > 255) ? 1 : 0;
   endfunction

   function automatic logic [15:0] rand_sample();
      int x;
      case ($urandom_range(0, 3))
         0: x = int'($urandom_range(0, 255));
         1: x = int'($urandom_range(256, 400));
         2: x = -int'($urandom_range(1, 300));
         default: x = int'($urandom_range(0, 65535));
      endcase
      return 16'(x);
   endfunction

   function automatic bit near_boundary(input int k);
      return (k < 4) || (k >= 38398 && k <= 38401) || (k >= 57598 && k <= 57601) ||
             (k >= FRAME_WORDS - 2);
   endfunction

   // One clock of stimulus, driven on the falling edge; the model predicts the next rising edge.
   task automatic drive_cycle(input bit v, input logic [31:0] d, input bit st, input bit log_all);
      rec_t r;
      @(negedge clk);
      bus.in_valid = v;
      bus.in_data  = d;
      start_bit    = st;
      r.acc = 1'b0; r.fin = 1'b0; r.addr = '0; r.data = '0; r.k = m_k; r.log_it = 1'b0;
      case (m_state)
         0: if (st) begin
               m_state = 1;
               m_k = 0;
               m_cc = 0;
            end
         1: if (v) begin
               r.acc  = 1'b1;
               r.k    = m_k;
               r.addr = 18'(ref_addr(m_k));
               r.data = {8'(clip_val(d[31:16])), 8'(clip_val(d[15:0]))};
               r.log_it = log_all || near_boundary(m_k);
               m_cc = m_cc + clip_hit(d[31:16]) + clip_hit(d[15:0]);
               if (m_cc > 131071) m_cc = 131071;
               m_k++;
               if (m_k == FRAME_WORDS) begin
                  m_state = 2;
                  r.fin = 1'b1;
               end
            end
         default: m_state = 0;
      endcase
      r.rdy = (m_state == 1);
      r.cc  = m_cc;
      exp_q.push_back(r);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      #2;
      resetn = 1'b0;
      exp_q.delete();
      m_state = 0;
      m_k = 0;
      m_cc = 0;
      bus.in_valid = 1'b0;
      start_bit = 1'b0;
      repeat (2) @(negedge clk);
      resetn = 1'b1;
   endtask

   // Monitor: one expected record per rising edge, compared 1 time unit after the edge.
   initial begin : monitor
      rec_t r;
      logic [17:0] last_addr;
      logic [15:0] last_data;
      int last_cc;
      last_addr = '0;
      last_data = '0;
      last_cc = 0;
      forever begin
         @(posedge clk);
         #1;
         if (!resetn) begin
            last_addr = '0;
            last_data = '0;
            last_cc = 0;
         end else begin
            if (exp_q.size() > 0) begin
               r = exp_q.pop_front();
            end else begin
               r.acc = 1'b0; r.rdy = 1'b0; r.fin = 1'b0; r.addr = '0; r.data = '0;
               r.k = -1; r.cc = last_cc; r.log_it = 1'b0;
            end
            checks++;
            if (bus.write_en_n !== (r.acc ? 1'b0 : 1'b1)) begin
               errors++;
               $display("FAIL write_en_n: got %b want %b (k=%0d)", bus.write_en_n, !r.acc, r.k);
            end
            if (r.acc) begin
               last_addr = r.addr;
               last_data = r.data;
            end
            checks++;
            if (bus.address !== last_addr) begin
               errors++;
               $display("FAIL address: got %0d want %0d (k=%0d)", bus.address, last_addr, r.k);
            end
            checks++;
            if (bus.write_data !== last_data) begin
               errors++;
               $display("FAIL write_data: got %h want %h (k=%0d)", bus.write_data, last_data, r.k);
            end
            checks++;
            if (bus.in_ready !== r.rdy) begin
               errors++;
               $display("FAIL in_ready: got %b want %b (k=%0d)", bus.in_ready, r.rdy, r.k);
            end
            checks++;
            if (writer_finish !== r.fin) begin
               errors++;
               $display("FAIL writer_finish: got %b want %b (k=%0d)", writer_finish, r.fin, r.k);
            end
`ifdef BLOCK_WRITER_CLIP_STATS_EN
            last_cc = r.cc;
            checks++;
            if (clip_count !== 17'(r.cc)) begin
               errors++;
               $display("FAIL clip_count: got %0d want %0d (k=%0d)", clip_count, r.cc, r.k);
            end
`endif
            if (r.acc && r.log_it)
               $display("write k=%0d addr=%0d data=%h", r.k, bus.address, bus.write_data);
         end
      end
   end

   // Reset takes effect at once, without waiting for a clock edge.
   initial begin : reset_watch
      forever begin
         @(negedge resetn);
         #1;
         checks++;
         if (bus.write_en_n !== 1'b1 || bus.address !== 18'd0 || bus.in_ready !== 1'b0 ||
             writer_finish !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got we_n=%b addr=%0d rdy=%b fin=%b want 1/0/0/0",
                     bus.write_en_n, bus.address, bus.in_ready, writer_finish);
         end
      end
   end

   initial begin : driver
      logic [31:0] d;
      int n;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      repeat (3) drive_cycle(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1);  // valid while idle is ignored

      // Frame A: directed words, then random traffic, aborted by reset after word 500
      drive_cycle(1'b0, '0, 1'b1, 1'b1);
      for (int i = 0; i < 32; i++) drive_cycle(1'b1, {16'd100, 16'hFFFB}, 1'b0, 1'b1);
      drive_cycle(1'b1, {16'd300, 16'hFFFF}, 1'b0, 1'b1);
      drive_cycle(1'b1, {16'd255, 16'd0}, 1'b0, 1'b1);
      drive_cycle(1'b1, {16'hFED4, 16'd256}, 1'b0, 1'b1);
      drive_cycle(1'b1, {rand_sample(), rand_sample()}, 1'b0, 1'b1);
      drive_cycle(1'b0, {rand_sample(), rand_sample()}, 1'b0, 1'b1);
      drive_cycle(1'b0, {rand_sample(), rand_sample()}, 1'b0, 1'b1);
      drive_cycle(1'b1, {rand_sample(), rand_sample()}, 1'b0, 1'b1);
      n = 0;
      while (m_k < 500 && n < 3000) begin
         d = {rand_sample(), rand_sample()};
         drive_cycle($urandom_range(0, 2) != 0, d, $urandom_range(0, 15) == 0, 1'b1);
         n++;
      end
      pulse_reset();
      repeat (3) drive_cycle(1'b0, '0, 1'b0, 1'b1);

      // Frame B: full frame, restarted from Y_BASE, with sparse bubbles and stray starts
      drive_cycle(1'b0, '0, 1'b1, 1'b0);
      n = 0;
      while (m_state != 0 && n < 90000) begin
         d = {rand_sample(), rand_sample()};
         drive_cycle($urandom_range(0, 31) != 0, d,
                     (m_state == 2) || ($urandom_range(0, 255) == 0), 1'b0);
         n++;
      end
      checks++;
      if (m_state != 0) begin
         errors++;
         $display("FAIL frame_budget: got %0d words want %0d", m_k, FRAME_WORDS);
      end
      repeat (4) drive_cycle(1'b1, {rand_sample(), rand_sample()}, 1'b0, 1'b0);
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
